// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters exclusive access
// to a shared register bank, with ack timeout and error reporting.
module reg_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          error,
  output logic                          bank_req,
  output logic                          bank_we,
  output logic [ADDR_WIDTH-1:0]         bank_addr,
  output logic [DATA_WIDTH-1:0]         bank_wdata,
  input  logic                          bank_ack,
  input  logic [DATA_WIDTH-1:0]         bank_rdata
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    COMPLETE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;
  logic [7:0]      cnt;
  logic [IDXW-1:0] win_idx;
  logic            win_any;

  // Scan from the highest offset down so the closest requester to ptr wins.
  always_comb begin
    win_idx = ptr;
    win_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        win_idx = IDXW'(j);
        win_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
      rdata      <= '0;
      error      <= 1'b0;
      bank_req   <= 1'b0;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= '0;
          if (win_any) begin
            owner      <= win_idx;
            grant      <= NUM_REQ'(1) << win_idx;
            bank_we    <= req_we[win_idx];
            bank_addr  <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bank_wdata <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
            bank_req   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          bank_req <= 1'b0;
          cnt      <= '0;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack in the final wait cycle takes priority over the timeout.
          if (bank_ack) begin
            rdata <= bank_rdata;
            error <= 1'b0;
            done  <= grant;
            state <= COMPLETE;
          end else if (cnt == CNT_LAST) begin
            rdata <= '0;
            error <= 1'b1;
            done  <= grant;
            state <= COMPLETE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COMPLETE: begin
          done  <= '0;
          grant <= '0;
          ptr   <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: read, round-robin, timeout,
// ack/timeout race, reset abort and stray acks.
module tb_reg_access_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic [DW-1:0] rdata;
  logic          error;
  logic          bank_req;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic          bank_ack;
  logic [DW-1:0] bank_rdata;

  int pass_cnt = 0;
  int total    = 0;

  reg_access_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .grant(grant),
    .done(done),
    .rdata(rdata),
    .error(error),
    .bank_req(bank_req),
    .bank_we(bank_we),
    .bank_addr(bank_addr),
    .bank_wdata(bank_wdata),
    .bank_ack(bank_ack),
    .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(grant), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_error"}, 64'(error), 0);
    chk({tag, "_rdata"}, 64'(rdata), 0);
    chk({tag, "_breq"}, 64'(bank_req), 0);
    chk({tag, "_bwe"}, 64'(bank_we), 0);
    chk({tag, "_baddr"}, 64'(bank_addr), 0);
    chk({tag, "_bwdata"}, 64'(bank_wdata), 0);
  endtask

  initial begin
    logic [N-1:0] e;
    reset = 1'b1;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    bank_ack = 1'b0;
    bank_rdata = '0;
    tick;
    tick;
    chk_all_zero("rst");
    reset = 1'b0;

    // single read, ack two cycles after bank_req
    req = 4'b0001;
    req_addr[7:0] = 8'h10;
    tick;
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_breq", 64'(bank_req), 1);
    chk("t1_baddr", 64'(bank_addr), 64'h10);
    chk("t1_bwe", 64'(bank_we), 0);
    tick;
    chk("t1_breq_drop", 64'(bank_req), 0);
    tick;
    chk("t1_done_early", 64'(done), 0);
    bank_ack = 1'b1;
    bank_rdata = 32'hDEADBEEF;
    tick;
    bank_ack = 1'b0;
    bank_rdata = '0;
    req = '0;
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("t1_error", 64'(error), 0);
    tick;
    chk("t1_done_off", 64'(done), 0);
    chk("t1_grant_off", 64'(grant), 0);

    // stray ack while idle
    bank_ack = 1'b1;
    tick;
    bank_ack = 1'b0;
    chk("stray_done", 64'(done), 0);
    chk("stray_grant", 64'(grant), 0);
    chk("stray_breq", 64'(bank_req), 0);
    tick;
    chk("stray_done2", 64'(done), 0);
    chk("stray_rdata_hold", 64'(rdata), 64'hDEADBEEF);

    // round-robin with all requesters, ack always high
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req_addr = {8'h23, 8'h22, 8'h21, 8'h20};
    req = 4'b1111;
    bank_ack = 1'b1;
    bank_rdata = 32'h55AA0000;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      tick;
      chk($sformatf("rr%0d_grant", k), 64'(grant), 64'(e));
      chk($sformatf("rr%0d_baddr", k), 64'(bank_addr), 64'(8'h20 + k % 4));
      tick;
      tick;
      chk($sformatf("rr%0d_done", k), 64'(done), 64'(e));
      chk($sformatf("rr%0d_held", k), 64'(grant), 64'(e));
      tick;
      chk($sformatf("rr%0d_gap", k), 64'(grant), 0);
      chk($sformatf("rr%0d_done_off", k), 64'(done), 0);
    end
    req = '0;
    bank_ack = 1'b0;

    // timeout on a write from requester 2 (ptr is 1)
    req = 4'b0100;
    req_we = 4'b0100;
    req_wdata[64 +: 32] = 32'hCAFEF00D;
    tick;
    chk("to_grant", 64'(grant), 64'h4);
    chk("to_bwe", 64'(bank_we), 1);
    chk("to_bwdata", 64'(bank_wdata), 64'hCAFEF00D);
    tick;
    for (int i = 0; i < TO - 1; i++) begin
      tick;
      chk($sformatf("to_wait%0d", i), 64'(done), 0);
    end
    tick;
    chk("to_done", 64'(done), 64'h4);
    chk("to_error", 64'(error), 1);
    chk("to_rdata", 64'(rdata), 0);
    req = '0;
    req_we = '0;
    tick;
    chk("to_error_hold", 64'(error), 1);

    // ack in the last wait cycle; ptr must now be 3
    req = 4'b1111;
    tick;
    chk("race_grant_ptr3", 64'(grant), 64'h8);
    tick;
    for (int i = 0; i < TO - 1; i++) tick;
    bank_ack = 1'b1;
    bank_rdata = 32'h12345678;
    tick;
    bank_ack = 1'b0;
    req = '0;
    chk("race_done", 64'(done), 64'h8);
    chk("race_error", 64'(error), 0);
    chk("race_rdata", 64'(rdata), 64'h12345678);
    tick;

    // move ptr to 2, then abort a transaction with reset
    req = 4'b0010;
    bank_ack = 1'b1;
    bank_rdata = 32'h0F0F0F0F;
    tick;
    tick;
    tick;
    chk("pre_done", 64'(done), 64'h2);
    req = '0;
    bank_ack = 1'b0;
    tick;
    req = 4'b1000;
    req_wdata[96 +: 32] = 32'h0BADF00D;
    tick;
    chk("ab_grant", 64'(grant), 64'h8);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req = 4'b1001;
    chk_all_zero("ab");
    tick;
    chk("ab_ptr0_grant", 64'(grant), 64'h1);
    chk("ab_no_done", 64'(done), 0);
    bank_ack = 1'b1;
    tick;
    tick;
    chk("ab_done", 64'(done), 64'h1);
    bank_ack = 1'b0;
    req = 4'b0010;
    tick;
    chk("ab_idle_done", 64'(done), 0);
    tick;
    chk("ab_next_grant", 64'(grant), 64'h2);
    req = '0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 8: register address width.
REQ-003 Parameter DATA_WIDTH, default 32: register data width.
REQ-004 Parameter TIMEOUT, default 15: maximum cycles to wait for bank_ack, range 1..255.
REQ-005 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 req  input  NUM_REQ: per-requester access request, level-held until done.
REQ-008 req_we  input  NUM_REQ: per-requester write enable (1 = write, 0 = read).
REQ-009 req_addr  input  NUM_REQ*ADDR_WIDTH: per-requester address, packed with requester 0 in the LSBs.
REQ-010 req_wdata  input  NUM_REQ*DATA_WIDTH: per-requester write data, packed the same way.
REQ-011 grant  output  NUM_REQ: one-hot, held for the owner for the whole transaction.
REQ-012 done  output  NUM_REQ: one-cycle one-hot completion pulse to the owner.
REQ-013 rdata  output  DATA_WIDTH: read data, valid in the cycle done is high.
REQ-014 error  output  1: high together with done when the transaction timed out.
REQ-015 bank_req  output  1: request to the shared register bank.
REQ-016 bank_we, bank_addr, bank_wdata  output  1/ADDR_WIDTH/DATA_WIDTH: registered copy of the owner's command.
REQ-017 bank_ack  input  1: bank completion strobe.
REQ-018 bank_rdata  input  DATA_WIDTH: bank read data, valid with bank_ack.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_ACK and COMPLETE.
REQ-020 IDLE: if any req bit is high, the arbiter SHALL select a winner by round-robin starting at index ptr, assert grant, latch the winner's we/addr/wdata into the bank_* registers, and go to ISSUE.
REQ-021 ISSUE: the arbiter SHALL drive bank_req high for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
REQ-022 WAIT_ACK: on bank_ack the arbiter SHALL capture bank_rdata into rdata with error=0 and go to COMPLETE.
REQ-023 WAIT_ACK with no bank_ack: the counter SHALL increment; when it reaches TIMEOUT, the arbiter SHALL set error=1, set rdata=0 and go to COMPLETE.
REQ-024 COMPLETE: the arbiter SHALL pulse done for the owner for one cycle, drop grant at the end of that cycle, set ptr = owner+1 (wrapping NUM_REQ-1 -> 0), and return to IDLE.
REQ-025 Latency from req sampled in IDLE to done SHALL be 3 + k cycles, where bank_ack arrives k cycles after bank_req (k >= 0; bank_ack in the bank_req cycle is ignored).
REQ-026 Back-to-back: the minimum gap between consecutive grants SHALL be one IDLE cycle.
REQ-027 A req bit that drops while granted SHALL NOT abort the transaction; it completes normally.
REQ-028 bank_ack outside WAIT_ACK SHALL be ignored.
REQ-029 A bank_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: error=0.
REQ-030 grant and done SHALL be zero or one-hot at all times.
REQ-031 rdata and error SHALL hold their value until the next COMPLETE.

Reset
REQ-032 While reset is high at a clock edge, the FSM SHALL go to IDLE, ptr to 0, and grant, done, error, rdata, bank_req, bank_we, bank_addr, bank_wdata and the counter to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no done pulse, and no bank_req SHALL be issued in the first cycle after reset deasserts.

Verification
REQ-034 Single read: req=0001, addr 0x10; bank_ack 2 cycles after bank_req with rdata 0xDEADBEEF -> done=0001 at cycle 5, rdata=0xDEADBEEF, error=0.
REQ-035 Round-robin: req=1111 held, immediate ack -> grants in order 0001,0010,0100,1000,0001, each grant one-hot.
REQ-036 Timeout: req=0100 write, bank_ack never asserted -> done=0100 with error=1 and rdata=0 exactly TIMEOUT cycles after entering WAIT_ACK; ptr=3.
REQ-037 Ack-at-timeout race: bank_ack in the cycle the counter reaches TIMEOUT -> error=0 and rdata captured.
REQ-038 Reset during WAIT_ACK: assert reset for 1 cycle -> all outputs 0, no done pulse, and the next req=0010 is granted from ptr=0.
REQ-039 Late ack: a stray bank_ack in IDLE -> no done pulse and no state change.
